ccl_merge_resolver: RTL and testbench

- Parametrised equivalence engine for the connected-components labeller. Owns the label allocator, ping-pong merge stacks and merge table.
- Adds three things to the current single-write merge logic: chain-safe merge resolution, a frame-end drain plus flatten pass, and overflow/saturation reporting.
- Sits between the label selector (new-label and merge requests) and the data/statistics tables (resolved-label lookups).

---
 rtl/ccl_merge_resolver_pkg.sv | 17 +
 rtl/ccl_merge_resolver_lifo.sv | 62 ++++++
 rtl/ccl_merge_resolver.sv | 191 +++++++++++++++++++
 tb/tb_ccl_merge_resolver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ccl_merge_resolver_pkg.sv
// rtl/ccl_merge_resolver_pkg.sv - shared types for the CCL merge resolver
package ccl_merge_resolver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_FLATTEN = 2'd2
  } state_e;

  // Per-index sub-steps of the flatten walk.
  typedef enum logic [1:0] {
    FL_RD_SELF = 2'd0,
    FL_RD_ROOT = 2'd1,
    FL_WRITE   = 2'd2
  } flat_phase_e;

endpackage

// File: rtl/ccl_merge_resolver_lifo.sv
// rtl/ccl_merge_resolver_lifo.sv - merge-pair LIFO with registered top
// Port a (new requests) is accepted before port b (push-backs) when both arrive together.
module ccl_merge_resolver_lifo #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_a_i,
  input  logic [DW-1:0] data_a_i,
  input  logic          push_b_i,
  input  logic [DW-1:0] data_b_i,
  input  logic          pop_i,
  output logic [DW-1:0] top_o,
  output logic          empty_o,
  output logic          drop_o
);
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  logic [DW-1:0] mem_q [1 << AW];
  logic [DW-1:0] top_q;
  logic [AW:0]   cnt_q, cnt_d, cnt_mid, below;
  logic          acc_a, acc_b, do_pop;

  always_comb begin
    acc_a   = push_a_i && (cnt_q != DEPTH_C);
    cnt_mid = cnt_q + {{AW{1'b0}}, acc_a};
    acc_b   = push_b_i && (cnt_mid != DEPTH_C);
    do_pop  = pop_i && (cnt_q != '0);
    cnt_d   = cnt_mid + {{AW{1'b0}}, acc_b} - {{AW{1'b0}}, do_pop};
    below   = cnt_q - TWO_C;
  end

  assign drop_o  = (push_a_i && !acc_a) || (push_b_i && !acc_b);
  assign empty_o = (cnt_q == '0);
  assign top_o   = top_q;

  always_ff @(posedge clk) begin
    if (acc_a) mem_q[cnt_q[AW-1:0]] <= data_a_i;
    if (acc_b) mem_q[cnt_mid[AW-1:0]] <= data_b_i;
  end

  // Pops never coincide with pushes on the same stack, so top is a simple mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      top_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      top_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (acc_b)       top_q <= data_b_i;
      else if (acc_a)  top_q <= data_a_i;
      else if (do_pop) top_q <= (cnt_q > ONE_C) ? mem_q[below[AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/ccl_merge_resolver.sv
// rtl/ccl_merge_resolver.sv - label allocator, ping-pong merge stacks and merge table
// Chain-safe pop engine, frame-end drain plus ascending flatten, sticky overflow/saturation.
module ccl_merge_resolver
  import ccl_merge_resolver_pkg::*;
#(
  parameter int LBL_WIDTH    = 8,
  parameter int STACK_AW     = 8,
  parameter int LOOKUP_PORTS = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              en,
  input  logic                              frame_start,
  input  logic                              frame_end,
  input  logic                              row_sel,
  input  logic                              new_label,
  input  logic                              merge_valid,
  input  logic [LBL_WIDTH-1:0]              merge_max,
  input  logic [LBL_WIDTH-1:0]              merge_min,
  output logic [LBL_WIDTH-1:0]              alloc_label,
  input  logic [LOOKUP_PORTS*LBL_WIDTH-1:0] lookup_addr,
  output logic [LOOKUP_PORTS*LBL_WIDTH-1:0] lookup_data,
  output logic [LBL_WIDTH-1:0]              num_labels,
  output logic                              busy,
  output logic                              flatten_done,
  output logic                              stack_overflow,
  output logic                              label_sat
);
  localparam int              LW        = LBL_WIDTH;
  localparam logic [LW-1:0]   MAX_LABEL = '1;
  localparam logic [LW-1:0]   ONE       = LW'(1);

  logic [LW-1:0] tbl_q [1 << LW];

  state_e        state_q;
  flat_phase_e   fphase_q;
  logic [LW-1:0] num_q, idx_q, rd_q, pmax_q, pmin_q;
  logic          wr_pend_q, src_q, busy_q, done_q, ovf_q, sat_q;
  logic [LOOKUP_PORTS*LW-1:0] lk_q;

  logic [1:0]      push_a, push_b, pop, empty, drop;
  logic [2*LW-1:0] stk_top [2];

  logic          idle, alloc, req_push, pop_sel, rd_go, pw_go, pb_need, fl_we, rd_en, we;
  logic [LW-1:0] top_max, top_min, t_min, t_max, rd_addr, waddr, wdata;

  always_comb begin
    idle     = (state_q == ST_IDLE);
    alloc    = idle && en && new_label;
    req_push = idle && en && merge_valid && (merge_max != merge_min);
    // Outside a frame tail the previous row's stack drains; DRAIN empties stack 0 first.
    pop_sel  = idle ? ~row_sel : empty[0];
    rd_go    = !wr_pend_q && !empty[pop_sel] && (state_q != ST_FLATTEN);
    {top_max, top_min} = stk_top[pop_sel];
    t_min    = (rd_q < pmin_q) ? rd_q : pmin_q;
    t_max    = (rd_q < pmin_q) ? pmin_q : rd_q;
    pw_go    = wr_pend_q && !alloc;
    pb_need  = pw_go && (rd_q != pmax_q) && (rd_q != pmin_q);
    fl_we    = (state_q == ST_FLATTEN) && (fphase_q == FL_WRITE);
    rd_en    = rd_go || ((state_q == ST_FLATTEN) && (fphase_q != FL_WRITE));
    rd_addr  = rd_go ? top_max : ((fphase_q == FL_RD_SELF) ? idx_q : rd_q);
    we       = !frame_start && (alloc || pw_go || fl_we);
    waddr    = alloc ? num_q : (pw_go ? pmax_q : idx_q);
    wdata    = alloc ? num_q : (pw_go ? t_min : rd_q);
    for (int s = 0; s < 2; s++) begin
      push_a[s] = req_push && (row_sel == s[0]);
      push_b[s] = pb_need && (src_q == s[0]);
      pop[s]    = rd_go && (pop_sel == s[0]);
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_stk
    ccl_merge_resolver_lifo #(.DW(2*LW), .AW(STACK_AW)) u_lifo (
      .clk      (clk),
      .rst_n    (reset_n),
      .clear_i  (frame_start),
      .push_a_i (push_a[s]),
      .data_a_i ({merge_max, merge_min}),
      .push_b_i (push_b[s]),
      .data_b_i ({t_max, t_min}),
      .pop_i    (pop[s]),
      .top_o    (stk_top[s]),
      .empty_o  (empty[s]),
      .drop_o   (drop[s])
    );
  end

  always_ff @(posedge clk) begin
    if (we) tbl_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_q <= '0;
      rd_q <= '0;
    end else begin
      for (int p = 0; p < LOOKUP_PORTS; p++)
        lk_q[p*LW +: LW] <= tbl_q[lookup_addr[p*LW +: LW]];
      if (rd_en) rd_q <= tbl_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      fphase_q  <= FL_RD_SELF;
      num_q     <= ONE;
      idx_q     <= ONE;
      pmax_q    <= '0;
      pmin_q    <= '0;
      wr_pend_q <= 1'b0;
      src_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else if (frame_start) begin
      state_q   <= ST_IDLE;
      fphase_q  <= FL_RD_SELF;
      num_q     <= ONE;
      idx_q     <= ONE;
      wr_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (alloc) begin
        if (num_q == MAX_LABEL) sat_q <= 1'b1;
        else                    num_q <= num_q + ONE;
      end
      if (|drop) ovf_q <= 1'b1;
      if (rd_go) begin
        wr_pend_q <= 1'b1;
        src_q     <= pop_sel;
        pmax_q    <= top_max;
        pmin_q    <= top_min;
      end else if (pw_go) begin
        wr_pend_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_end) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if ((empty == 2'b11) && !wr_pend_q) begin
            if (num_q == ONE) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ST_FLATTEN;
              idx_q    <= ONE;
              fphase_q <= FL_RD_SELF;
            end
          end
        end
        ST_FLATTEN: begin
          case (fphase_q)
            FL_RD_SELF: fphase_q <= FL_RD_ROOT;
            FL_RD_ROOT: fphase_q <= FL_WRITE;
            default: begin
              fphase_q <= FL_RD_SELF;
              if (idx_q == num_q - ONE) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + ONE;
              end
            end
          endcase
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alloc_label    = num_q;
  assign num_labels     = num_q;
  assign lookup_data    = lk_q;
  assign busy           = busy_q;
  assign flatten_done   = done_q;
  assign stack_overflow = ovf_q;
  assign label_sat      = sat_q;

endmodule

// File: tb/tb_ccl_merge_resolver.sv
// tb/tb_ccl_merge_resolver.sv - directed scoreboard bench for ccl_merge_resolver
module tb_ccl_merge_resolver;
  localparam int LW  = 3;
  localparam int SAW = 2;
  localparam int LP  = 1;

  logic          clk = 1'b0;
  logic          reset_n, en, frame_start, frame_end, row_sel, new_label, merge_valid;
  logic [LW-1:0] merge_max, merge_min, alloc_label, num_labels;
  logic [LP*LW-1:0] lookup_addr, lookup_data;
  logic          busy, flatten_done, stack_overflow, label_sat;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int exp_q[$];
  int cyc;

  always #5 clk = ~clk;

  ccl_merge_resolver #(.LBL_WIDTH(LW), .STACK_AW(SAW), .LOOKUP_PORTS(LP)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .frame_start(frame_start), .frame_end(frame_end),
    .row_sel(row_sel), .new_label(new_label), .merge_valid(merge_valid),
    .merge_max(merge_max), .merge_min(merge_min), .alloc_label(alloc_label),
    .lookup_addr(lookup_addr), .lookup_data(lookup_data), .num_labels(num_labels),
    .busy(busy), .flatten_done(flatten_done), .stack_overflow(stack_overflow),
    .label_sat(label_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_lookup(input int addr, input int exp);
    int e;
    lookup_addr = LW'(addr);
    exp_q.push_back(exp);
    tick();
    e = exp_q.pop_front();
    check($sformatf("lookup(%0d)", addr), int'(lookup_data), e);
  endtask

  task automatic alloc_n(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      en = 1'b1;
      new_label = 1'b1;
      check($sformatf("%s alloc_label #%0d", tag, k), int'(alloc_label), (k < 7) ? k : 7);
      tick();
    end
    en = 1'b0;
    new_label = 1'b0;
  endtask

  task automatic push_pair(input int mx, input int mn);
    en = 1'b1;
    merge_valid = 1'b1;
    merge_max = LW'(mx);
    merge_min = LW'(mn);
    tick();
    en = 1'b0;
    merge_valid = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic end_frame(output int cycles);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    cycles = 0;
    while (flatten_done !== 1'b1 && cycles < 300) begin
      tick();
      cycles++;
    end
    check("flatten_done seen", int'(flatten_done), 1);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; frame_start = 1'b0; frame_end = 1'b0; row_sel = 1'b0;
    new_label = 1'b0; merge_valid = 1'b0; merge_max = '0; merge_min = '0; lookup_addr = '0;
    repeat (2) tick();
    check("reset num_labels", int'(num_labels), 1);
    check("reset alloc_label", int'(alloc_label), 1);
    check("reset lookup_data", int'(lookup_data), 0);
    check("reset busy", int'(busy), 0);
    check("reset flatten_done", int'(flatten_done), 0);
    check("reset stack_overflow", int'(stack_overflow), 0);
    check("reset label_sat", int'(label_sat), 0);
    reset_n = 1'b1;
    tick();
    pulse_frame_start();

    alloc_n(5, "basic");
    check("basic num_labels", int'(num_labels), 6);
    do_lookup(3, 3);

    // (5,3) then (5,2) in row 0; popping (5,3) after table[5]=2 forces a push-back of (3,2).
    row_sel = 1'b0;
    push_pair(5, 3);
    push_pair(5, 2);
    row_sel = 1'b1;
    end_frame(cyc);
    check("merge busy after done", int'(busy), 0);
    do_lookup(5, 2);
    do_lookup(3, 2);
    do_lookup(4, 4);
    do_lookup(1, 1);

    pulse_frame_start();
    alloc_n(4, "chain");
    row_sel = 1'b0;
    push_pair(4, 3);
    push_pair(3, 2);
    push_pair(2, 1);
    end_frame(cyc);
    // 3 entries x 2 cycles, 1 handoff cycle, then 3 cycles for each of labels 1..4.
    check("chain drain+flatten cycles", cyc, 3*2 + 1 + 3*4);
    tick();
    check("flatten_done one pulse", int'(flatten_done), 0);
    do_lookup(2, 1);
    do_lookup(3, 1);
    do_lookup(4, 1);

    pulse_frame_start();
    alloc_n(6, "ovf");
    row_sel = 1'b0;
    push_pair(2, 1);
    push_pair(3, 1);
    push_pair(4, 1);
    push_pair(5, 1);
    check("overflow before fifth", int'(stack_overflow), 0);
    push_pair(6, 1);
    check("overflow after fifth", int'(stack_overflow), 1);
    end_frame(cyc);
    do_lookup(2, 1);
    do_lookup(5, 1);
    do_lookup(6, 6);
    pulse_frame_start();
    check("overflow cleared", int'(stack_overflow), 0);

    alloc_n(6, "sat");
    check("sat not yet", int'(label_sat), 0);
    check("sat num_labels at max", int'(num_labels), 7);
    for (int k = 7; k <= 8; k++) begin
      en = 1'b1;
      new_label = 1'b1;
      check($sformatf("sat alloc_label #%0d", k), int'(alloc_label), 7);
      tick();
    end
    en = 1'b0;
    new_label = 1'b0;
    check("sat flag", int'(label_sat), 1);
    check("sat num_labels held", int'(num_labels), 7);

    pulse_frame_start();
    check("frame_start clears sat", int'(label_sat), 0);
    alloc_n(3, "stall");
    row_sel = 1'b0;
    push_pair(3, 1);
    row_sel = 1'b1;
    tick();
    en = 1'b1;
    new_label = 1'b1;
    do_lookup(3, 3);
    en = 1'b0;
    new_label = 1'b0;
    check("stall num_labels", int'(num_labels), 5);
    do_lookup(3, 3);
    do_lookup(3, 1);
    do_lookup(4, 4);

    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    repeat (4) tick();
    check("busy in flatten", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("async reset busy", int'(busy), 0);
    check("async reset num_labels", int'(num_labels), 1);
    check("async reset lookup_data", int'(lookup_data), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post reset flatten_done", int'(flatten_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
